// File: rtl/dcpu_pkg.sv
// Shared definitions for the dcpu memory-side bus controller: FSM states,
// I/O page register offsets and CTRL register bit positions.
package dcpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_e;

  localparam logic [3:0] IO_CNT    = 4'd0;
  localparam logic [3:0] IO_RELOAD = 4'd1;
  localparam logic [3:0] IO_CTRL   = 4'd2;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_PEND = 1;
  localparam int CTRL_IE   = 2;

endpackage

// File: rtl/dcpu_ram.sv
// Single-port synchronous RAM with registered read data; a read on the
// cycle of a same-address write returns the old contents.
module dcpu_ram #(
  parameter int W  = 16,
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        mem[i_addr] <= i_wdata;
      end
      o_rdata <= mem[i_addr];
    end
  end

endmodule

// File: rtl/dcpu_bus_ctrl.sv
// Bus slave for the dcpu core serving on-chip RAM and a 16-word I/O page.
// The interval timer in the I/O page is built only when DCPU_TIMER_EN is defined.
module dcpu_bus_ctrl
  import dcpu_pkg::*;
#(
  parameter int           W       = 16,
  parameter int           AW      = 12,
  parameter int           WAIT    = 0,
  parameter logic [W-1:0] IO_BASE = 16'hFFF0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_cs,
  input  logic         i_we,
  input  logic [W-1:0] i_addr,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_ack,
  output logic         o_irq
);

  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
`ifdef DCPU_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  bus_state_e   state;
  logic [3:0]   wait_cnt;
  logic         rd_ram_q;
  logic [W-1:0] io_rdata_q;
  logic [W-1:0] io_rd;
  logic [W-1:0] ram_rdata;
  logic         req;
  logic         hit_ram;
  logic         hit_io;
  logic         ram_en;

  // Handshake: i_cs/i_we/i_addr/i_dat form a request the core holds until
  // o_ack; it is sampled only in IDLE, and o_ack is a single-cycle pulse.
  assign req     = (state == ST_IDLE) && i_cs;
  assign hit_ram = (i_addr >> AW) == '0;
  assign hit_io  = TIMER_ON && (i_addr[W-1:4] == IO_BASE[W-1:4]);
  assign ram_en  = req && hit_ram;

  dcpu_ram #(
    .W  (W),
    .AW (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_en    (ram_en),
    .i_we    (i_we),
    .i_addr  (i_addr[AW-1:0]),
    .i_wdata (i_dat),
    .o_rdata (ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      rd_ram_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_cs) begin
            rd_ram_q   <= hit_ram && !i_we;
            io_rdata_q <= (hit_io && !i_we) ? io_rd : '0;
            if (WAIT > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= ST_ACK;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_ack = (state == ST_ACK);
  assign o_dat = o_ack ? ((rd_ram_q ? ram_rdata : '0) | io_rdata_q) : '0;

`ifdef DCPU_TIMER_EN
  logic [W-1:0] cnt_q, reload_q, cnt_d, reload_d;
  logic         en_q, pend_q, ie_q, irq_q;
  logic         en_d, pend_d, ie_d;
  logic         tick, io_wr;

  assign io_wr = req && i_we && hit_io;
  assign tick  = en_q && (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    en_d     = en_q;
    ie_d     = ie_q;
    pend_d   = pend_q;
    if (en_q) begin
      cnt_d = tick ? reload_q : cnt_q - 1'b1;
    end
    if (io_wr) begin
      case (i_addr[3:0])
        IO_RELOAD: reload_d = i_dat;
        IO_CTRL: begin
          en_d = i_dat[CTRL_EN];
          ie_d = i_dat[CTRL_IE];
          if (i_dat[CTRL_PEND]) pend_d = 1'b0;
          if (i_dat[CTRL_EN] && !en_q) cnt_d = reload_q;
        end
        default: ;
      endcase
    end
    // A timer expiry in the same cycle as a CPU clear keeps PEND set.
    if (tick) pend_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q    <= '0;
      reload_q <= '0;
      en_q     <= 1'b0;
      pend_q   <= 1'b0;
      ie_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
      ie_q     <= ie_d;
      irq_q    <= pend_d && ie_d;
    end
  end

  always_comb begin
    io_rd = '0;
    case (i_addr[3:0])
      IO_CNT:    io_rd = cnt_q;
      IO_RELOAD: io_rd = reload_q;
      IO_CTRL:   io_rd = W'({ie_q, pend_q, en_q});
      default:   io_rd = '0;
    endcase
  end

  assign o_irq = irq_q;
`else
  assign io_rd = '0;
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_dcpu_bus_ctrl.sv
// Bench for dcpu_bus_ctrl: a zero-wait and a two-wait instance checked against
// a memory model and an arithmetic timer model.
module tb_dcpu_bus_ctrl;

  localparam int          WAIT2   = 2;
  localparam logic [15:0] IO_BASE = 16'hFFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs0, we0, ack0, irq0;
  logic [15:0] addr0, wdat0, rdat0;
  logic        cs2, we2, ack2, irq2;
  logic [15:0] addr2, wdat2, rdat2;

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mem0 [int];
  logic [15:0] mem2 [int];
  int tm_e0, tm_r, tm_clr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcpu_bus_ctrl #(.W(16), .AW(12), .WAIT(0), .IO_BASE(IO_BASE)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_cs(cs0), .i_we(we0), .i_addr(addr0),
    .i_dat(wdat0), .o_dat(rdat0), .o_ack(ack0), .o_irq(irq0)
  );

  dcpu_bus_ctrl #(.W(16), .AW(12), .WAIT(WAIT2), .IO_BASE(IO_BASE)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_cs(cs2), .i_we(we2), .i_addr(addr2),
    .i_dat(wdat2), .o_dat(rdat2), .o_ack(ack2), .o_irq(irq2)
  );

  // One bus transaction; checks latency, idle o_dat and single-cycle ack.
  task automatic bus_xfer(input bit sel2, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdat, output logic [15:0] rdat,
                          output int latch_cyc);
    int lat, exp_lat;
    bit got;
    logic ack;
    logic [15:0] dat;
    exp_lat = sel2 ? 1 + WAIT2 : 1;
    if (sel2) begin cs2 = 1'b1; we2 = we; addr2 = addr; wdat2 = wdat; end
    else      begin cs0 = 1'b1; we0 = we; addr0 = addr; wdat0 = wdat; end
    lat = 0; got = 1'b0; rdat = '0;
    latch_cyc = cyc + 1;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      ack = sel2 ? ack2 : ack0;
      dat = sel2 ? rdat2 : rdat0;
      if (ack === 1'b1) begin
        got = 1'b1;
        rdat = dat;
      end else begin
        checks++;
        if (dat !== 16'h0) $display("FAIL odat_idle dut%0d got=%h want=0000", sel2 ? 2 : 0, dat);
        else passed++;
      end
    end
    if (sel2) cs2 = 1'b0; else cs0 = 1'b0;
    checks++;
    if (!got || lat != exp_lat)
      $display("FAIL latency dut%0d addr=%h got=%0d want=%0d", sel2 ? 2 : 0, addr, got ? lat : -1, exp_lat);
    else passed++;
    @(posedge clk); #1;
    ack = sel2 ? ack2 : ack0;
    dat = sel2 ? rdat2 : rdat0;
    checks++;
    if (ack !== 1'b0 || dat !== 16'h0)
      $display("FAIL ack_pulse dut%0d got ack=%b dat=%h want ack=0 dat=0000", sel2 ? 2 : 0, ack, dat);
    else passed++;
  endtask

  task automatic test_reset();
    logic [15:0] obs [6];
    string nm [6];
    rst = 1'b1;
    cs0 = 0; we0 = 0; addr0 = '0; wdat0 = '0;
    cs2 = 0; we2 = 0; addr2 = '0; wdat2 = '0;
    repeat (3) @(posedge clk);
    #1;
    obs = '{16'(ack0), rdat0, 16'(irq0), 16'(ack2), rdat2, 16'(irq2)};
    nm  = '{"ack0", "dat0", "irq0", "ack2", "dat2", "irq2"};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs[i] !== 16'h0) $display("FAIL reset_%s got=%h want=0000", nm[i], obs[i]);
      else passed++;
    end
    rst = 1'b0;
  endtask

  task automatic test_ram_basic();
    logic [15:0] rd;
    int lc;
    bus_xfer(0, 1, 16'h0005, 16'h1234, rd, lc); mem0[5] = 16'h1234;
    bus_xfer(0, 0, 16'h0005, 16'h0000, rd, lc);
    checks++;
    if (rd !== 16'h1234) $display("FAIL ram_read5 got=%h want=1234", rd); else passed++;
    bus_xfer(0, 1, 16'h0010, 16'hBEEF, rd, lc); mem0[16] = 16'hBEEF;
    bus_xfer(0, 0, 16'h0010, 16'h0000, rd, lc);
    checks++;
    if (rd !== 16'hBEEF) $display("FAIL ram_read10 got=%h want=beef", rd); else passed++;
  endtask

  task automatic test_ram_random(input bit sel2);
    int addrs[$];
    logic [15:0] rd, d, exp;
    int a, lc;
    for (int i = 0; i < 12; i++) begin
      a = (i == 0) ? 12'hFFF : (i == 1) ? 0 : int'($urandom_range(0, 4095));
      d = 16'($urandom);
      bus_xfer(sel2, 1, 16'(a), d, rd, lc);
      if (sel2) mem2[a] = d; else mem0[a] = d;
      addrs.push_back(a);
      a = addrs[$urandom_range(0, addrs.size() - 1)];
      exp_q.push_back(sel2 ? mem2[a] : mem0[a]);
      bus_xfer(sel2, 0, 16'(a), 16'h0, rd, lc);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) $display("FAIL ram_rand dut%0d addr=%h got=%h want=%h", sel2 ? 2 : 0, a, rd, exp);
      else passed++;
    end
  endtask

  task automatic test_unmapped();
    logic [15:0] rd, a;
    int lc;
    bus_xfer(0, 1, 16'h0000, 16'hA5C3, rd, lc); mem0[0] = 16'hA5C3;
    bus_xfer(0, 1, 16'h2000, 16'h5555, rd, lc);
    bus_xfer(0, 0, 16'h2000, 16'h0, rd, lc);
    checks++;
    if (rd !== 16'h0) $display("FAIL unmapped_2000 got=%h want=0000", rd); else passed++;
    bus_xfer(0, 0, 16'h0000, 16'h0, rd, lc);
    checks++;
    if (rd !== mem0[0]) $display("FAIL ram0_intact got=%h want=%h", rd, mem0[0]); else passed++;
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom_range(16'h1000, 16'hFFEF));
      bus_xfer(0, 1, a, 16'($urandom), rd, lc);
      bus_xfer(0, 0, a, 16'h0, rd, lc);
      checks++;
      if (rd !== 16'h0) $display("FAIL unmapped_rand addr=%h got=%h want=0000", a, rd); else passed++;
    end
  endtask

`ifdef DCPU_TIMER_EN
  // Expiries happen at tm_e0 + k*(tm_r+1), k >= 1.
  function automatic int next_set(input int c);
    int k;
    k = (c - tm_e0 + tm_r) / (tm_r + 1);
    if (k < 1) k = 1;
    return tm_e0 + k * (tm_r + 1);
  endfunction

  function automatic bit pend_after(input int c);
    return next_set(tm_clr) <= c;
  endfunction

  task automatic wait_until(input int target);
    int guard;
    guard = 0;
    while (cyc + 1 < target && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic test_timer();
    logic [15:0] rd, exp;
    int lc, lr, n;
    tm_r = $urandom_range(3, 8);
    bus_xfer(0, 1, IO_BASE | 16'd1, 16'(tm_r), rd, lc);
    bus_xfer(0, 1, IO_BASE | 16'd2, 16'h0005, rd, tm_e0);
    tm_clr = tm_e0;
    for (int i = 0; i < 2 * (tm_r + 1) + 1; i++) begin
      @(posedge clk); #1;
      checks++;
      if (irq0 !== pend_after(cyc))
        $display("FAIL timer_irq cyc=%0d got=%b want=%b", cyc - tm_e0, irq0, pend_after(cyc));
      else passed++;
    end
    bus_xfer(0, 0, IO_BASE, 16'h0, rd, lr);
    exp = 16'(tm_r - ((lr - 1 - tm_e0) % (tm_r + 1)));
    checks++;
    if (rd !== exp) $display("FAIL timer_cnt got=%h want=%h", rd, exp); else passed++;
    bus_xfer(0, 0, IO_BASE | 16'd1, 16'h0, rd, lr);
    checks++;
    if (rd !== 16'(tm_r)) $display("FAIL timer_reload got=%h want=%h", rd, 16'(tm_r)); else passed++;
    n = next_set(cyc + 1);
    wait_until(n + 1);
    bus_xfer(0, 1, IO_BASE | 16'd2, 16'h0007, rd, lc);
    tm_clr = lc;
    bus_xfer(0, 0, IO_BASE | 16'd2, 16'h0, rd, lr);
    exp = 16'h0005 | (16'(pend_after(lr - 1)) << 1);
    checks++;
    if (rd !== exp) $display("FAIL pend_clear got=%h want=%h", rd, exp); else passed++;
    n = next_set(cyc + 1);
    wait_until(n);
    bus_xfer(0, 1, IO_BASE | 16'd2, 16'h0007, rd, lc);
    tm_clr = lc;
    bus_xfer(0, 0, IO_BASE | 16'd2, 16'h0, rd, lr);
    exp = 16'h0005 | (16'(pend_after(lr - 1)) << 1);
    checks++;
    if (rd !== exp) $display("FAIL pend_set_wins got=%h want=%h", rd, exp); else passed++;
    bus_xfer(0, 0, IO_BASE | 16'($urandom_range(3, 15)), 16'h0, rd, lr);
    checks++;
    if (rd !== 16'h0) $display("FAIL io_other got=%h want=0000", rd); else passed++;
    bus_xfer(0, 1, IO_BASE | 16'd2, 16'h0000, rd, lc);
    checks++;
    if (irq0 !== 1'b0) $display("FAIL irq_off got=%b want=0", irq0); else passed++;
  endtask
`else
  task automatic test_io_disabled();
    logic [15:0] rd;
    int lc;
    bus_xfer(0, 1, IO_BASE | 16'd1, 16'h0000, rd, lc);
    bus_xfer(0, 1, IO_BASE | 16'd2, 16'h0005, rd, lc);
    for (int i = 0; i < 3; i++) begin
      bus_xfer(0, 0, IO_BASE | 16'(i), 16'h0, rd, lc);
      checks++;
      if (rd !== 16'h0) $display("FAIL io_disabled off=%0d got=%h want=0000", i, rd); else passed++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (irq0 !== 1'b0) $display("FAIL irq_tied got=%b want=0", irq0); else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    logic [15:0] rd, v;
    int lc;
    v = 16'($urandom);
    bus_xfer(1, 1, 16'h0123, v, rd, lc); mem2[16'h0123] = v;
`ifdef DCPU_TIMER_EN
    bus_xfer(1, 1, IO_BASE | 16'd1, 16'h0000, rd, lc);
    bus_xfer(1, 1, IO_BASE | 16'd2, 16'h0005, rd, lc);
    @(posedge clk); #1;
    checks++;
    if (irq2 !== 1'b1) $display("FAIL reload0_irq got=%b want=1", irq2); else passed++;
`endif
    cs2 = 1'b1; we2 = 1'b0; addr2 = 16'h0123;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cs2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ack2 !== 1'b0 || irq2 !== 1'b0)
        $display("FAIL reset_abort cyc=%0d got ack=%b irq=%b want ack=0 irq=0", i, ack2, irq2);
      else passed++;
      @(posedge clk); #1;
    end
    bus_xfer(1, 0, IO_BASE | 16'd2, 16'h0, rd, lc);
    checks++;
    if (rd !== 16'h0) $display("FAIL ctrl_after_reset got=%h want=0000", rd); else passed++;
    bus_xfer(1, 0, 16'h0123, 16'h0, rd, lc);
    checks++;
    if (rd !== mem2[16'h0123]) $display("FAIL read_after_reset got=%h want=%h", rd, mem2[16'h0123]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_ram_basic();
    test_ram_random(1'b0);
    test_unmapped();
    test_ram_random(1'b1);
`ifdef DCPU_TIMER_EN
    test_timer();
`else
    test_io_disabled();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
